spi_slave_regif: RTL and testbench

- SPI mode-0 responder for the 56-bit management frame driven by the team's SPI master.
- Frame, MSB first: rw(1) | port_no(2) | dev_addr(5) | reg_addr(16) | data(32). rw=1 is read, rw=0 is write.
- Oversamples sck/ssn/mosi in the clk domain and converts each frame into a single-cycle register write or read request toward a local register file.
- Returns read data on miso during the 32 data bit times.

---
 rtl/spi_slave_regif.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_slave_regif.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regif.sv
// SPI mode-0 responder for the 56-bit management frame: rw | port | dev | reg | data.
// Oversamples the SPI pins in clk and turns each frame into one register write or read request.
`timescale 1ns/1ps
module spi_slave_regif #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [4:0] DEV_ADDR    = 5'd0,
  parameter bit         MATCH_ALL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sck,
  input  logic        ssn,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic [1:0]  port_no,
  output logic [15:0] reg_addr,
  output logic [4:0]  dev_addr_o,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic        rd_req,
  input  logic [31:0] rd_data,
  input  logic        rd_ack,
  output logic        busy,
  output logic        frame_err,
  output logic        rd_late
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_RDATA, S_WDATA, S_SKIP, S_END} state_t;
  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sck_sync_reg, sck_sync_next;
  logic [SYNC_STAGES-1:0] ssn_sync_reg, ssn_sync_next;
  logic [SYNC_STAGES-1:0] mosi_sync_reg, mosi_sync_next;
  logic sck_q_reg, ssn_q_reg, ssn_seen_reg;
  logic sck_s, ssn_s, mosi_s;
  logic sck_rise, sck_fall, ssn_rise;

  logic [5:0]  bit_cnt_reg;
  logic [23:0] hdr_reg;
  logic [23:0] hdr_full;
  logic [31:0] rd_buf_reg, tx_reg, tx_load, wr_data_reg;
  logic        rd_seen_reg, tx_loaded_reg;
  logic        miso_reg, miso_oe_reg, wr_en_reg, rd_req_reg;
  logic        busy_reg, frame_err_reg, rd_late_reg;
  logic [1:0]  port_no_reg;
  logic [15:0] reg_addr_reg;
  logic [4:0]  dev_addr_reg;
  logic        hdr_done, last_rise, addr_hit, in_frame, abort;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_in
        assign sck_sync_next[gi]  = sck;
        assign ssn_sync_next[gi]  = ssn;
        assign mosi_sync_next[gi] = mosi;
      end else begin : g_chain
        assign sck_sync_next[gi]  = sck_sync_reg[gi-1];
        assign ssn_sync_next[gi]  = ssn_sync_reg[gi-1];
        assign mosi_sync_next[gi] = mosi_sync_reg[gi-1];
      end
    end
  endgenerate

  // ssn chain resets low so a frame in flight at reset cannot look like a fresh ssn-high
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sck_sync_reg  <= '0;
      ssn_sync_reg  <= '0;
      mosi_sync_reg <= '0;
      sck_q_reg     <= 1'b0;
      ssn_q_reg     <= 1'b0;
      ssn_seen_reg  <= 1'b0;
    end else begin
      sck_sync_reg  <= sck_sync_next;
      ssn_sync_reg  <= ssn_sync_next;
      mosi_sync_reg <= mosi_sync_next;
      sck_q_reg     <= sck_s;
      ssn_q_reg     <= ssn_s;
      if (ssn_s) ssn_seen_reg <= 1'b1;
    end
  end

  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign ssn_s    = ssn_sync_reg[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q_reg;
  assign sck_fall = ~sck_s & sck_q_reg;
  assign ssn_rise = ssn_s & ~ssn_q_reg;

  assign hdr_full  = {hdr_reg[22:0], mosi_s};
  assign hdr_done  = sck_rise && (bit_cnt_reg == 6'd23);
  assign last_rise = sck_rise && (bit_cnt_reg == 6'd55);
  assign addr_hit  = MATCH_ALL || (hdr_full[20:16] == DEV_ADDR);
  assign in_frame  = (state_reg == S_HDR) || (state_reg == S_RDATA) ||
                     (state_reg == S_WDATA) || (state_reg == S_SKIP);
  // an ssn rise coinciding with the 56th sck rise completes the frame
  assign abort     = in_frame && ssn_rise && !last_rise;
  assign tx_load   = rd_ack ? rd_data : (rd_seen_reg ? rd_buf_reg : 32'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (!ssn_s && ssn_seen_reg) state_next = S_HDR;
      S_HDR: begin
        if (abort)               state_next = S_IDLE;
        else if (hdr_done) begin
          if (!addr_hit)         state_next = S_SKIP;
          else if (hdr_full[23]) state_next = S_RDATA;
          else                   state_next = S_WDATA;
        end
      end
      S_RDATA, S_WDATA, S_SKIP: begin
        if (abort)          state_next = S_IDLE;
        else if (last_rise) state_next = S_END;
      end
      S_END:   if (ssn_s) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt_reg   <= '0;
      hdr_reg       <= '0;
      rd_buf_reg    <= '0;
      tx_reg        <= '0;
      wr_data_reg   <= '0;
      rd_seen_reg   <= 1'b0;
      tx_loaded_reg <= 1'b0;
      miso_reg      <= 1'b0;
      miso_oe_reg   <= 1'b0;
      wr_en_reg     <= 1'b0;
      rd_req_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      rd_late_reg   <= 1'b0;
      port_no_reg   <= '0;
      reg_addr_reg  <= '0;
      dev_addr_reg  <= '0;
    end else begin
      wr_en_reg     <= 1'b0;
      rd_req_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
      rd_late_reg   <= 1'b0;
      busy_reg      <= (state_next != S_IDLE);

      if (state_reg == S_IDLE) begin
        bit_cnt_reg   <= '0;
        hdr_reg       <= '0;
        rd_seen_reg   <= 1'b0;
        tx_loaded_reg <= 1'b0;
        miso_reg      <= 1'b0;
        miso_oe_reg   <= 1'b0;
      end else if (sck_rise && (bit_cnt_reg != 6'd56)) begin
        bit_cnt_reg <= bit_cnt_reg + 6'd1;
      end

      case (state_reg)
        S_HDR: begin
          if (sck_rise) hdr_reg <= hdr_full;
          if (hdr_done) begin
            port_no_reg  <= hdr_full[22:21];
            dev_addr_reg <= hdr_full[20:16];
            reg_addr_reg <= hdr_full[15:0];
            if (addr_hit && hdr_full[23] && !abort) rd_req_reg <= 1'b1;
          end
        end
        S_RDATA: begin
          if (rd_ack && !tx_loaded_reg) begin
            rd_buf_reg  <= rd_data;
            rd_seen_reg <= 1'b1;
          end
          if (sck_fall) begin
            if (!tx_loaded_reg) begin
              tx_loaded_reg <= 1'b1;
              miso_oe_reg   <= 1'b1;
              tx_reg        <= tx_load;
              miso_reg      <= tx_load[31];
              if (!rd_seen_reg && !rd_ack) rd_late_reg <= 1'b1;
            end else begin
              tx_reg   <= {tx_reg[30:0], 1'b0};
              miso_reg <= tx_reg[30];
            end
          end
        end
        S_WDATA: begin
          if (sck_rise) begin
            wr_data_reg <= {wr_data_reg[30:0], mosi_s};
            if (last_rise) wr_en_reg <= 1'b1;
          end
        end
        S_END: begin
          if (ssn_s) begin
            miso_reg    <= 1'b0;
            miso_oe_reg <= 1'b0;
          end
        end
        default: ;
      endcase

      if (abort) begin
        frame_err_reg <= 1'b1;
        miso_reg      <= 1'b0;
        miso_oe_reg   <= 1'b0;
      end
    end
  end

  assign miso       = miso_reg;
  assign miso_oe    = miso_oe_reg;
  assign port_no    = port_no_reg;
  assign reg_addr   = reg_addr_reg;
  assign dev_addr_o = dev_addr_reg;
  assign wr_en      = wr_en_reg;
  assign wr_data    = wr_data_reg;
  assign rd_req     = rd_req_reg;
  assign busy       = busy_reg;
  assign frame_err  = frame_err_reg;
  assign rd_late    = rd_late_reg;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: a bit-banged SPI master, a register-file responder
// and a filtered (DEV_ADDR=3) plus a match-all instance sharing the same bus.
`timescale 1ns/1ps
module tb_spi_slave_regif;
  localparam int HALF = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sck = 1'b0, ssn = 1'b1, mosi = 1'b0;
  logic [31:0] rd_data;
  logic rd_ack;

  logic miso, miso_oe, wr_en, rd_req, busy, frame_err, rd_late;
  logic [1:0] port_no;
  logic [15:0] reg_addr;
  logic [4:0] dev_addr_o;
  logic [31:0] wr_data;

  logic a_miso, a_miso_oe, a_wr_en, a_rd_req, a_busy, a_frame_err, a_rd_late;
  logic [1:0] a_port_no;
  logic [15:0] a_reg_addr;
  logic [4:0] a_dev_addr_o;
  logic [31:0] a_wr_data;

  always #5 clk = ~clk;

  spi_slave_regif #(.SYNC_STAGES(2), .DEV_ADDR(5'h03), .MATCH_ALL(1'b0)) u_dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .ssn(ssn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .port_no(port_no), .reg_addr(reg_addr),
    .dev_addr_o(dev_addr_o), .wr_en(wr_en), .wr_data(wr_data), .rd_req(rd_req),
    .rd_data(rd_data), .rd_ack(rd_ack), .busy(busy), .frame_err(frame_err), .rd_late(rd_late));

  spi_slave_regif #(.SYNC_STAGES(2), .DEV_ADDR(5'h03), .MATCH_ALL(1'b1)) u_all (
    .clk(clk), .reset_n(reset_n), .sck(sck), .ssn(ssn), .mosi(mosi),
    .miso(a_miso), .miso_oe(a_miso_oe), .port_no(a_port_no), .reg_addr(a_reg_addr),
    .dev_addr_o(a_dev_addr_o), .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_req(a_rd_req),
    .rd_data(rd_data), .rd_ack(rd_ack), .busy(a_busy), .frame_err(a_frame_err), .rd_late(a_rd_late));

  int checks = 0, errors = 0;

  // event counters, only ever incremented here; tests compare deltas
  int wr_cnt = 0, rd_cnt = 0, ferr_cnt = 0, late_cnt = 0, act_cnt = 0;
  int a_wr_cnt = 0, a_rd_cnt = 0;
  logic [31:0] wr_cap = '0, a_wr_cap = '0;
  logic [15:0] addr_cap = '0;
  logic [1:0]  port_cap = '0;
  logic [4:0]  dev_cap = '0;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++; wr_cap = wr_data; addr_cap = reg_addr; port_cap = port_no; dev_cap = dev_addr_o;
    end
    if (rd_req) begin
      rd_cnt++; addr_cap = reg_addr; port_cap = port_no; dev_cap = dev_addr_o;
    end
    if (frame_err) ferr_cnt++;
    if (rd_late) late_cnt++;
    if (miso || miso_oe) act_cnt++;
    if (a_wr_en) begin a_wr_cnt++; a_wr_cap = a_wr_data; end
    if (a_rd_req) a_rd_cnt++;
  end

  // register-file model: answers u_dut's rd_req two clocks later when enabled
  logic ack_en = 1'b0;
  initial begin
    rd_ack = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (rd_req && ack_en) begin
        @(negedge clk);
        @(negedge clk);
        rd_data = 32'hA5A50F0F;
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        rd_data = '0;
      end
    end
  end

  logic [31:0] rx;
  int oe_rises;
  logic busy_mid;
  logic [6:0] snap_bits;
  logic [15:0] snap_addr;
  logic [1:0] snap_port;
  logic [4:0] snap_dev;
  logic [31:0] snap_wdata;

  task automatic spi_frame(input logic [55:0] bits, input int nbits, input int rst_bit);
    rx = '0;
    oe_rises = 0;
    busy_mid = 1'b0;
    @(negedge clk);
    #2;
    ssn = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        snap_bits  = {miso, miso_oe, busy, wr_en, rd_req, frame_err, rd_late};
        snap_addr  = reg_addr;
        snap_port  = port_no;
        snap_dev   = dev_addr_o;
        snap_wdata = wr_data;
        #2;
      end
      mosi = bits[55-i];
      #HALF;
      if (i == 10) busy_mid = busy;
      if (i >= 24) rx = {rx[30:0], miso};
      if (miso_oe) oe_rises++;
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
    #HALF;
    ssn = 1'b1;
    mosi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if ({miso, miso_oe, busy} !== 3'b000) begin errors++; $display("FAIL reset_miso_oe_busy got %b exp 000", {miso, miso_oe, busy}); end
    checks++; if ({wr_en, rd_req, frame_err, rd_late} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {wr_en, rd_req, frame_err, rd_late}); end
    checks++; if ({port_no, reg_addr, dev_addr_o} !== 23'd0) begin errors++; $display("FAIL reset_fields got %h exp 0", {port_no, reg_addr, dev_addr_o}); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
  endtask

  task automatic test_write_hit();
    int w0, f0, r0;
    w0 = wr_cnt; f0 = ferr_cnt; r0 = rd_cnt;
    spi_frame({1'b0, 2'd2, 5'd3, 16'h1234, 32'hDEADBEEF}, 56, -1);
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL wr_hit_count got %0d exp 1", wr_cnt - w0); end
    checks++; if (wr_cap !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_hit_data got %h exp deadbeef", wr_cap); end
    checks++; if (addr_cap !== 16'h1234) begin errors++; $display("FAIL wr_hit_addr got %h exp 1234", addr_cap); end
    checks++; if (port_cap !== 2'd2 || dev_cap !== 5'd3) begin errors++; $display("FAIL wr_hit_port_dev got %0d/%0d exp 2/3", port_cap, dev_cap); end
    checks++; if (ferr_cnt - f0 !== 0 || rd_cnt - r0 !== 0) begin errors++; $display("FAIL wr_hit_other got ferr %0d rd %0d exp 0 0", ferr_cnt - f0, rd_cnt - r0); end
    checks++; if (busy_mid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wr_hit_busy got mid %b end %b exp 1 0", busy_mid, busy); end
  endtask

  task automatic test_read_hit();
    int r0, l0, w0;
    r0 = rd_cnt; l0 = late_cnt; w0 = wr_cnt;
    ack_en = 1'b1;
    spi_frame({1'b1, 2'd1, 5'd3, 16'h0010, 32'h0}, 56, -1);
    checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL rd_hit_count got %0d exp 1", rd_cnt - r0); end
    checks++; if (rx !== 32'hA5A50F0F) begin errors++; $display("FAIL rd_hit_data got %h exp a5a50f0f", rx); end
    checks++; if (oe_rises !== 32) begin errors++; $display("FAIL rd_hit_oe got %0d exp 32", oe_rises); end
    checks++; if (late_cnt - l0 !== 0 || wr_cnt - w0 !== 0) begin errors++; $display("FAIL rd_hit_other got late %0d wr %0d exp 0 0", late_cnt - l0, wr_cnt - w0); end
    checks++; if (addr_cap !== 16'h0010 || port_cap !== 2'd1) begin errors++; $display("FAIL rd_hit_addr got %h/%0d exp 0010/1", addr_cap, port_cap); end
    checks++; if ({miso, miso_oe} !== 2'b00) begin errors++; $display("FAIL rd_hit_idle_miso got %b exp 00", {miso, miso_oe}); end
  endtask

  task automatic test_read_late();
    int r0, l0;
    r0 = rd_cnt; l0 = late_cnt;
    ack_en = 1'b0;
    spi_frame({1'b1, 2'd0, 5'd3, 16'h0020, 32'h0}, 56, -1);
    checks++; if (late_cnt - l0 !== 1) begin errors++; $display("FAIL rd_late_count got %0d exp 1", late_cnt - l0); end
    checks++; if (rx !== 32'h0) begin errors++; $display("FAIL rd_late_data got %h exp 0", rx); end
    checks++; if (rd_cnt - r0 !== 1 || busy !== 1'b0) begin errors++; $display("FAIL rd_late_req_busy got %0d %b exp 1 0", rd_cnt - r0, busy); end
  endtask

  task automatic test_addr_miss();
    int w0, r0, c0, aw0, ar0;
    w0 = wr_cnt; r0 = rd_cnt; c0 = act_cnt; aw0 = a_wr_cnt; ar0 = a_rd_cnt;
    ack_en = 1'b1;
    spi_frame({1'b0, 2'd0, 5'h07, 16'h0040, 32'h12345678}, 56, -1);
    spi_frame({1'b1, 2'd0, 5'h07, 16'h0044, 32'h0}, 56, -1);
    checks++; if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin errors++; $display("FAIL miss_strobes got wr %0d rd %0d exp 0 0", wr_cnt - w0, rd_cnt - r0); end
    checks++; if (act_cnt - c0 !== 0) begin errors++; $display("FAIL miss_miso got %0d active cycles exp 0", act_cnt - c0); end
    checks++; if (a_wr_cnt - aw0 !== 1 || a_wr_cap !== 32'h12345678) begin errors++; $display("FAIL match_all_wr got %0d %h exp 1 12345678", a_wr_cnt - aw0, a_wr_cap); end
    checks++; if (a_rd_cnt - ar0 !== 1) begin errors++; $display("FAIL match_all_rd got %0d exp 1", a_rd_cnt - ar0); end
  endtask

  task automatic test_abort();
    int w0, f0;
    w0 = wr_cnt; f0 = ferr_cnt;
    spi_frame({1'b0, 2'd1, 5'd3, 16'h00AA, 32'h0BADF00D}, 40, -1);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL abort_ferr got %0d exp 1", ferr_cnt - f0); end
    checks++; if (wr_cnt - w0 !== 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_wr_busy got %0d %b exp 0 0", wr_cnt - w0, busy); end
    w0 = wr_cnt; f0 = ferr_cnt;
    spi_frame({1'b0, 2'd1, 5'd3, 16'h00AA, 32'h0BADF00D}, 56, -1);
    checks++; if (wr_cnt - w0 !== 1 || wr_cap !== 32'h0BADF00D) begin errors++; $display("FAIL abort_next_wr got %0d %h exp 1 0badf00d", wr_cnt - w0, wr_cap); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL abort_next_ferr got %0d exp 0", ferr_cnt - f0); end
  endtask

  task automatic test_reset_mid();
    int w0, f0;
    w0 = wr_cnt; f0 = ferr_cnt;
    spi_frame({1'b0, 2'd3, 5'd3, 16'h5555, 32'hCAFEF00D}, 56, 30);
    checks++; if (snap_bits !== 7'd0) begin errors++; $display("FAIL rst_mid_bits got %b exp 0", snap_bits); end
    checks++; if ({snap_port, snap_addr, snap_dev} !== 23'd0 || snap_wdata !== 32'd0) begin errors++; $display("FAIL rst_mid_fields got %h %h exp 0 0", {snap_port, snap_addr, snap_dev}, snap_wdata); end
    checks++; if (wr_cnt - w0 !== 0 || ferr_cnt - f0 !== 0) begin errors++; $display("FAIL rst_mid_strobes got wr %0d ferr %0d exp 0 0", wr_cnt - w0, ferr_cnt - f0); end
    w0 = wr_cnt;
    spi_frame({1'b0, 2'd3, 5'd3, 16'h5555, 32'hCAFEF00D}, 56, -1);
    checks++; if (wr_cnt - w0 !== 1 || wr_cap !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_next_wr got %0d %h exp 1 cafef00d", wr_cnt - w0, wr_cap); end
    checks++; if (addr_cap !== 16'h5555 || port_cap !== 2'd3) begin errors++; $display("FAIL rst_next_addr got %h/%0d exp 5555/3", addr_cap, port_cap); end
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wr_cnt;
    spi_frame({1'b0, 2'd0, 5'd3, 16'h0001, 32'h11111111}, 56, -1);
    checks++; if (wr_cap !== 32'h11111111 || addr_cap !== 16'h0001) begin errors++; $display("FAIL b2b_first got %h/%h exp 11111111/0001", wr_cap, addr_cap); end
    spi_frame({1'b0, 2'd0, 5'd3, 16'h0002, 32'h22222222}, 56, -1);
    checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", wr_cnt - w0); end
    checks++; if (wr_cap !== 32'h22222222 || addr_cap !== 16'h0002) begin errors++; $display("FAIL b2b_second got %h/%h exp 22222222/0002", wr_cap, addr_cap); end
  endtask

  initial begin
    test_reset();
    test_write_hit();
    test_read_hit();
    test_read_late();
    test_addr_miss();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
